// File: rtl/sram_arbiter.sv
// Serialises the CPU instruction-fetch and data-memory ports onto one shared SRAM.
// Every SRAM-facing output is registered and decoded from the next state, so the pins never glitch.
module sram_arbiter #(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stall_o,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [31:0] sram_dq_i,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WS   = 3'd2,
    S_WP   = 3'd3,
    S_WH   = 3'd4
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
  localparam logic [3:0] WP_LAST = 4'(WR_PULSE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_mem_q, last_mem_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        grant_mem;

  // Only addr[21:2] reaches the SRAM; the remaining address bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    grant_mem   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A still-visible ack means the requester has not yet dropped req.
        if (!if_ack_q && !mem_ack_q && (if_req || mem_req)) begin
          grant_mem  = mem_req && (!if_req || !last_mem_q);
          last_mem_d = grant_mem;
          cnt_d      = 4'd0;
          if (grant_mem) begin
            addr_d  = mem_addr[21:2];
            sel_d   = mem_sel;
            wdata_d = mem_wdata;
            state_d = mem_we ? S_WS : S_RD;
          end else begin
            addr_d  = if_addr[21:2];
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          if (last_mem_q) begin
            mem_rdata_d = sram_dq_i;
            mem_ack_d   = 1'b1;
          end else begin
            if_rdata_d = sram_dq_i;
            if_ack_d   = 1'b1;
          end
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WS: begin
        cnt_d   = 4'd0;
        state_d = S_WP;
      end
      S_WP: begin
        if (cnt_q == WP_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_WH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WH: begin
        mem_ack_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes follow the state being entered, so they line up with it cycle for cycle.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = 4'hF;
    dq_oe_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      S_WS, S_WP, S_WH: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~sel_d;
        dq_oe_d = 1'b1;
        we_n_d  = (state_d != S_WP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      last_mem_q  <= 1'b0;
      addr_q      <= 20'd0;
      sel_q       <= 4'd0;
      wdata_q     <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ack     = if_ack_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_be_n  = be_n_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign stall_o    = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a byte-maskable SRAM model on the pad side.
module tb_sram_arbiter;
  localparam int RDW = 1;
  localparam int WRP = 2;

  logic        clk, rst_n;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, sram_dq_o, sram_dq_i;
  logic        if_ack, mem_ack, stall_o, sram_dq_oe;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  sram_arbiter #(.RD_WAIT(RDW), .WR_PULSE(WRP)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_o(stall_o), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_be_n(sram_be_n),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? ram[sram_addr[9:0]] : 32'h0;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) ram[sram_addr[9:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
  end

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int ackgrant_cnt = 0;

  always @(negedge clk) begin
    if (sram_dq_oe && !sram_oe_n) overlap_cnt++;
    if ((if_ack || mem_ack) && !sram_ce_n) ackgrant_cnt++;
  end

  int          lat, oe_cnt, we_cnt, dqoe_cnt;
  logic [3:0]  be_and, be_or;
  logic [19:0] addr_seen;

  // Issues one request at a negedge and samples the pins each following negedge until its ack.
  task automatic run_xact(input bit is_mem, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd);
    @(negedge clk);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    be_and = 4'hF; be_or = 4'h0; addr_seen = 20'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) dqoe_cnt++;
      if (!sram_ce_n) begin
        be_and = be_and & sram_be_n;
        be_or  = be_or | sram_be_n;
        addr_seen = sram_addr;
      end
      if (is_mem ? mem_ack : if_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    if_req = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !== 8'b1111_1110) begin
      errors++; $display("FAIL reset_strobes: got %b want 11111110",
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe});
    end
    checks++;
    if ({if_ack, mem_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_acks: got %b want 00", {if_ack, mem_ack});
    end
    checks++;
    if ({if_rdata, mem_rdata, sram_dq_o, sram_addr} !== 116'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want all zero",
                         if_rdata, mem_rdata, sram_dq_o, sram_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_ce_n, stall_o} !== 2'b10) begin
      errors++; $display("FAIL post_reset_idle: got ce_n=%b stall=%b want 1 0", sram_ce_n, stall_o);
    end
  endtask

  task automatic test_if_read();
    run_xact(1'b0, 1'b0, 32'h40, 4'h0, 32'h0);
    checks++;
    if (lat !== RDW + 2) begin
      errors++; $display("FAIL if_read_latency: got %0d want %0d", lat, RDW + 2);
    end
    checks++;
    if (oe_cnt !== RDW + 1) begin
      errors++; $display("FAIL if_read_oe_cycles: got %0d want %0d", oe_cnt, RDW + 1);
    end
    checks++;
    if (if_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL if_rdata: got %h want deadbeef", if_rdata);
    end
    checks++;
    if (addr_seen !== 20'h00010 || dqoe_cnt !== 0) begin
      errors++; $display("FAIL if_read_addr: got addr=%h dq_oe_cycles=%0d want 00010 0", addr_seen, dqoe_cnt);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL if_stall_at_ack: got %b want 0", stall_o);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_ack, stall_o} !== 2'b00) begin
      errors++; $display("FAIL if_ack_width: got ack=%b stall=%b want 0 0", if_ack, stall_o);
    end
  endtask

  task automatic test_alternate();
    logic [5:0] seq;
    int n;
    seq = 6'h0; n = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_sel = 4'hF;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      if (mem_ack) begin seq[n] = 1'b1; n++; end
      else if (if_ack) begin seq[n] = 1'b0; n++; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    checks++;
    if (n !== 6 || seq !== 6'b010101) begin
      errors++; $display("FAIL alternation: got n=%0d seq=%b want 6 010101 (bit0 first, 1=MEM)", n, seq);
    end
    checks++;
    if (if_rdata !== 32'h11112222 || mem_rdata !== 32'h33334444) begin
      errors++; $display("FAIL alternation_data: got %h %h want 11112222 33334444", if_rdata, mem_rdata);
    end
    checks++;
    if (ackgrant_cnt !== 0) begin
      errors++; $display("FAIL ack_with_grant: got %0d cycles want 0", ackgrant_cnt);
    end
  endtask

  task automatic test_mem_write();
    run_xact(1'b1, 1'b1, 32'h84, 4'b0011, 32'h12345678);
    checks++;
    if (lat !== WRP + 3) begin
      errors++; $display("FAIL write_latency: got %0d want %0d", lat, WRP + 3);
    end
    checks++;
    if (we_cnt !== WRP || oe_cnt !== 0) begin
      errors++; $display("FAIL write_we_width: got we=%0d oe=%0d want %0d 0", we_cnt, oe_cnt, WRP);
    end
    checks++;
    if (dqoe_cnt !== WRP + 2) begin
      errors++; $display("FAIL write_dq_oe: got %0d want %0d", dqoe_cnt, WRP + 2);
    end
    checks++;
    if (be_and !== 4'b1100 || be_or !== 4'b1100 || addr_seen !== 20'h21) begin
      errors++; $display("FAIL write_be_addr: got be=%b/%b addr=%h want 1100 00021", be_and, be_or, addr_seen);
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ack !== 1'b0) begin
      errors++; $display("FAIL write_ack_width: got %b want 0", mem_ack);
    end
    checks++;
    if (ram[10'h21] !== 32'hAAAA5678) begin
      errors++; $display("FAIL write_ram: got %h want aaaa5678", ram[10'h21]);
    end
  endtask

  task automatic test_back_to_back();
    run_xact(1'b1, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D);
    run_xact(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    mem_req = 1'b0;
    checks++;
    if (mem_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_rdata: got %h want cafef00d", mem_rdata);
    end
    checks++;
    if (lat !== RDW + 2) begin
      errors++; $display("FAIL b2b_read_latency: got %0d want %0d", lat, RDW + 2);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL oe_dq_overlap: got %0d cycles want 0", overlap_cnt);
    end
  endtask

  task automatic test_sel_zero();
    run_xact(1'b1, 1'b1, 32'h140, 4'b0000, 32'hFFFFFFFF);
    mem_req = 1'b0;
    checks++;
    if (be_and !== 4'hF || be_or !== 4'hF || we_cnt !== WRP) begin
      errors++; $display("FAIL sel0_be: got be=%b/%b we=%0d want 1111 %0d", be_and, be_or, we_cnt, WRP);
    end
    checks++;
    if (ram[10'h50] !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL sel0_ram: got %h want 5a5a5a5a", ram[10'h50]);
    end
    checks++;
    if (lat !== WRP + 3) begin
      errors++; $display("FAIL sel0_ack: got latency %0d want %0d", lat, WRP + 3);
    end
    @(negedge clk);
    checks++;
    if (mem_ack !== 1'b0) begin
      errors++; $display("FAIL sel0_ack_width: got %b want 0", mem_ack);
    end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    int acks;
    found = 1'b0; acks = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h180; mem_sel = 4'hF; mem_wdata = 32'h77777777;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (!sram_we_n) found = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!found || {sram_ce_n, sram_we_n, sram_dq_oe, mem_ack} !== 4'b1100) begin
      errors++; $display("FAIL reset_mid_write: got found=%b ce/we/dq_oe/ack=%b want 1 1100",
                         found, {sram_ce_n, sram_we_n, sram_dq_oe, mem_ack});
    end
    mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL reset_no_ack: got %0d acks want 0", acks);
    end
    run_xact(1'b0, 1'b0, 32'h40, 4'h0, 32'h0);
    if_req = 1'b0;
    checks++;
    if (if_rdata !== 32'hDEADBEEF || lat !== RDW + 2) begin
      errors++; $display("FAIL after_reset_read: got %h lat=%0d want deadbeef %0d", if_rdata, lat, RDW + 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h10] = 32'hDEADBEEF;
    ram[10'h21] = 32'hAAAAAAAA;
    ram[10'h50] = 32'h5A5A5A5A;
    ram[10'h80] = 32'h11112222;
    ram[10'hC0] = 32'h33334444;
    test_reset();
    test_if_read();
    test_alternate();
    test_mem_write();
    test_back_to_back();
    test_sel_zero();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
